// File: rtl/seg7_pkg.sv
// Shared constants for the 3-digit seven-segment scanner.
package seg7_pkg;

  localparam int unsigned DIGITS = 3;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_t;

  // Active-high g..a patterns, indexed by hex nibble.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high g..a segment decoder.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Table lookup; polarity is handled by the caller's output registers.
  always_comb begin
    seg = HEX_SEG[nib];
  end

endmodule

// File: rtl/seg7_scan.sv
// Three-digit multiplexed seven-segment scanner with per-slot blanking
// gap and frame-synchronous double-buffered display data.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned GAP_CYC     = 16,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          EN_ACT_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [11:0] wr_data,
  input  logic [2:0]  wr_dp,
  input  logic [2:0]  wr_blank,
  output logic [7:0]  seg,
  output logic [2:0]  seg_en,
  output logic        frame_tick
);

  localparam int unsigned CW      = $clog2(SCAN_DIV);
  localparam logic [7:0]  SEG_OFF = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [2:0]  EN_OFF  = EN_ACT_LOW  ? 3'b111 : 3'b000;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  scan_state_t   state_q, state_d;

  logic [11:0] pend_data_q, pend_data_d, disp_data_q, disp_data_d;
  logic [2:0]  pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic [2:0]  pend_blank_q, pend_blank_d, disp_blank_q, disp_blank_d;

  logic [7:0] seg_q, seg_d;
  logic [2:0] en_q, en_d;
  logic       tick_q, tick_d;

  logic       wrap, frame_end;
  logic [3:0] nib;
  logic       dp_sel, blank_sel;
  logic [6:0] dec_seg;
  logic [7:0] seg_raw;
  logic [2:0] en_raw;

  seg7_hex_decode u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  // Select the active digit's nibble and flags from the display set.
  always_comb begin
    nib       = disp_data_q[3:0];
    dp_sel    = disp_dp_q[0];
    blank_sel = disp_blank_q[0];
    case (idx_q)
      2'd1: begin
        nib       = disp_data_q[7:4];
        dp_sel    = disp_dp_q[1];
        blank_sel = disp_blank_q[1];
      end
      2'd2: begin
        nib       = disp_data_q[11:8];
        dp_sel    = disp_dp_q[2];
        blank_sel = disp_blank_q[2];
      end
      default: ;
    endcase
  end

  // Next-state: slot counter, digit index, FSM, register sets, outputs.
  always_comb begin
    wrap      = (cnt_q == CW'(SCAN_DIV - 1));
    frame_end = wrap && (idx_q == 2'd2);

    cnt_d = wrap ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (wrap) idx_d = (idx_q == 2'd2) ? '0 : idx_q + 2'd1;

    state_d = state_q;
    case (state_q)
      GAP:     if (cnt_q == CW'(GAP_CYC - 1)) state_d = SHOW;
      SHOW:    if (wrap) state_d = GAP;
      default: state_d = GAP;
    endcase

    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    if (wr_en) begin
      pend_data_d  = wr_data;
      pend_dp_d    = wr_dp;
      pend_blank_d = wr_blank;
    end

    // Display set samples the pending set's current value, so a coincident
    // write lands in pending only and shows one frame later.
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (frame_end) begin
      disp_data_d  = pend_data_q;
      disp_dp_d    = pend_dp_q;
      disp_blank_d = pend_blank_q;
    end

    seg_raw = '0;
    en_raw  = '0;
    if (state_q == SHOW) begin
      en_raw  = 3'b001 << idx_q;
      seg_raw = blank_sel ? 8'h00 : {dp_sel, dec_seg};
    end

    seg_d  = SEG_ACT_LOW ? ~seg_raw : seg_raw;
    en_d   = EN_ACT_LOW  ? ~en_raw  : en_raw;
    tick_d = frame_end;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= GAP;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= SEG_OFF;
      en_q         <= EN_OFF;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      en_q         <= en_d;
      tick_q       <= tick_d;
    end
  end

  assign seg        = seg_q;
  assign seg_en     = en_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan (SCAN_DIV=40, GAP_CYC=4).
module tb_seg7_scan;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [11:0] wr_data;
  logic [2:0]  wr_dp;
  logic [2:0]  wr_blank;
  logic [7:0]  seg;
  logic [2:0]  seg_en;
  logic        frame_tick;

  int total  = 0;
  int passed = 0;

  localparam logic [8:0] ENS_NORM = 9'b011_101_110;

  seg7_scan #(
    .SCAN_DIV    (40),
    .GAP_CYC     (4),
    .SEG_ACT_LOW (1'b1),
    .EN_ACT_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_dp      (wr_dp),
    .wr_blank   (wr_blank),
    .seg        (seg),
    .seg_en     (seg_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Waits (bounded) until a negedge where frame_tick is high.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 300);
    if (!frame_tick) begin
      total++;
      $display("FAIL wait_tick: no frame_tick within %0d cycles", n);
    end
  endtask

  // Starting at a tick negedge, walks one 120-cycle frame, sampling each
  // digit mid-SHOW and optionally issuing up to two writes at cycles wa/wb.
  task automatic capture_frame(
    input  int          wa,
    input  logic [11:0] da,
    input  logic [2:0]  pa,
    input  logic [2:0]  ba,
    input  int          wb,
    input  logic [11:0] db,
    input  logic [2:0]  pb,
    input  logic [2:0]  bb,
    output logic [23:0] segs,
    output logic [8:0]  ens,
    output logic        tick_end,
    output int          extra_ticks,
    output int          multi_en
  );
    segs = '0; ens = '0; tick_end = 1'b0; extra_ticks = 0; multi_en = 0;
    for (int j = 1; j <= 120; j++) begin
      @(negedge clk);
      if (j == 21)  begin segs[7:0]   = seg; ens[2:0] = seg_en; end
      if (j == 61)  begin segs[15:8]  = seg; ens[5:3] = seg_en; end
      if (j == 101) begin segs[23:16] = seg; ens[8:6] = seg_en; end
      if ($countones(~seg_en) > 1) multi_en++;
      if (j < 120 && frame_tick) extra_ticks++;
      if (j == 120) tick_end = frame_tick;
      if (j == wa) begin
        wr_en = 1'b1; wr_data = da; wr_dp = pa; wr_blank = ba;
      end else if (j == wb) begin
        wr_en = 1'b1; wr_data = db; wr_dp = pb; wr_blank = bb;
      end else begin
        wr_en = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] es;
    logic [2:0] ee;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (seg !== 8'hFF) $display("FAIL rst_seg: got %h expected ff", seg); else passed++;
    total++; if (seg_en !== 3'b111) $display("FAIL rst_en: got %b expected 111", seg_en); else passed++;
    total++; if (frame_tick !== 1'b0) $display("FAIL rst_tick: got %b expected 0", frame_tick); else passed++;
    reset = 1'b0;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) @(negedge clk);
      es = (c < 5) ? 8'hFF : 8'hC0;
      ee = (c < 5) ? 3'b111 : 3'b110;
      total++;
      if (seg !== es || seg_en !== ee)
        $display("FAIL idle_cycle%0d: got seg=%h en=%b expected seg=%h en=%b", c, seg, seg_en, es, ee);
      else passed++;
    end
  endtask

  task automatic test_idle_frame();
    logic [23:0] s; logic [8:0] e; logic t; int x; int m;
    wait_tick();
    capture_frame(0, '0, '0, '0, 0, '0, '0, '0, s, e, t, x, m);
    total++; if (s !== 24'hC0C0C0) $display("FAIL idle_segs: got %h expected c0c0c0", s); else passed++;
    total++; if (e !== ENS_NORM) $display("FAIL idle_ens: got %b expected %b", e, ENS_NORM); else passed++;
    total++; if (t !== 1'b1 || x !== 0) $display("FAIL idle_tick: got end=%b extra=%0d expected 1/0", t, x); else passed++;
    total++; if (m !== 0) $display("FAIL idle_multi_en: got %0d expected 0", m); else passed++;
  endtask

  task automatic test_write();
    logic [23:0] s; logic [8:0] e; logic t; int x; int m;
    capture_frame(50, 12'h18F, 3'b010, 3'b000, 0, '0, '0, '0, s, e, t, x, m);
    total++; if (s !== 24'hC0C0C0) $display("FAIL wr_cur_segs: got %h expected c0c0c0", s); else passed++;
    capture_frame(0, '0, '0, '0, 0, '0, '0, '0, s, e, t, x, m);
    total++; if (s !== 24'hF9008E) $display("FAIL wr_next_segs: got %h expected f9008e", s); else passed++;
    total++; if (e !== ENS_NORM) $display("FAIL wr_next_ens: got %b expected %b", e, ENS_NORM); else passed++;
  endtask

  task automatic test_last_write();
    logic [23:0] s; logic [8:0] e; logic t; int x; int m;
    capture_frame(10, 12'h123, 3'b000, 3'b000, 90, 12'h456, 3'b000, 3'b000, s, e, t, x, m);
    total++; if (s !== 24'hF9008E) $display("FAIL lww_cur_segs: got %h expected f9008e", s); else passed++;
    capture_frame(0, '0, '0, '0, 0, '0, '0, '0, s, e, t, x, m);
    total++; if (s !== 24'h999282) $display("FAIL lww_next_segs: got %h expected 999282", s); else passed++;
  endtask

  task automatic test_blank();
    logic [23:0] s; logic [8:0] e; logic t; int x; int m;
    capture_frame(30, 12'h456, 3'b000, 3'b100, 0, '0, '0, '0, s, e, t, x, m);
    total++; if (s !== 24'h999282) $display("FAIL blank_cur_segs: got %h expected 999282", s); else passed++;
    capture_frame(0, '0, '0, '0, 0, '0, '0, '0, s, e, t, x, m);
    total++; if (s !== 24'hFF9282) $display("FAIL blank_segs: got %h expected ff9282", s); else passed++;
    total++; if (e !== ENS_NORM) $display("FAIL blank_ens: got %b expected %b", e, ENS_NORM); else passed++;
  endtask

  task automatic test_coincident();
    logic [23:0] s; logic [8:0] e; logic t; int x; int m;
    capture_frame(119, 12'h789, 3'b000, 3'b000, 0, '0, '0, '0, s, e, t, x, m);
    capture_frame(0, '0, '0, '0, 0, '0, '0, '0, s, e, t, x, m);
    total++; if (s !== 24'hFF9282) $display("FAIL coinc_next_segs: got %h expected ff9282", s); else passed++;
    capture_frame(0, '0, '0, '0, 0, '0, '0, '0, s, e, t, x, m);
    total++; if (s !== 24'hF88090) $display("FAIL coinc_later_segs: got %h expected f88090", s); else passed++;
    total++; if (m !== 0) $display("FAIL coinc_multi_en: got %0d expected 0", m); else passed++;
  endtask

  task automatic test_frame_tick();
    int n; int m;
    wait_tick();
    n = 0; m = 0;
    do begin
      @(negedge clk);
      n++;
      if ($countones(~seg_en) > 1) m++;
    end while (!frame_tick && n < 300);
    total++; if (n !== 120) $display("FAIL tick_period: got %0d expected 120", n); else passed++;
    total++; if (m !== 0) $display("FAIL tick_multi_en: got %0d expected 0", m); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [23:0] s; logic [8:0] e; logic t; int x; int m;
    for (int j = 1; j <= 61; j++) begin
      @(negedge clk);
      if (j == 5) begin
        wr_en = 1'b1; wr_data = 12'hABC; wr_dp = 3'b111; wr_blank = 3'b000;
      end else begin
        wr_en = 1'b0;
      end
    end
    total++;
    if (seg !== 8'h80 || seg_en !== 3'b101)
      $display("FAIL mid_pre: got seg=%h en=%b expected seg=80 en=101", seg, seg_en);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (seg !== 8'hFF || seg_en !== 3'b111 || frame_tick !== 1'b0)
      $display("FAIL mid_rst: got seg=%h en=%b tick=%b expected ff/111/0", seg, seg_en, frame_tick);
    else passed++;
    reset = 1'b0;
    wait_tick();
    capture_frame(0, '0, '0, '0, 0, '0, '0, '0, s, e, t, x, m);
    total++; if (s !== 24'hC0C0C0) $display("FAIL mid_after_segs: got %h expected c0c0c0", s); else passed++;
    total++; if (e !== ENS_NORM) $display("FAIL mid_after_ens: got %b expected %b", e, ENS_NORM); else passed++;
  endtask

  initial begin
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    wr_dp    = '0;
    wr_blank = '0;
    test_reset();
    test_idle_frame();
    test_write();
    test_last_write();
    test_blank();
    test_coincident();
    test_frame_tick();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, clock cycles per digit slot (legal range 32..65535).
REQ-002 The block SHALL have parameter GAP_CYC, default 16, blanking cycles at the start of each slot (legal range 1..SCAN_DIV-1).
REQ-003 The block SHALL have parameter SEG_ACT_LOW, default 1; 1 means seg outputs drive 0 to light a segment.
REQ-004 The block SHALL have parameter EN_ACT_LOW, default 1; 1 means seg_en drives 0 to enable a digit.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port wr_en, input, 1 bit: a one-cycle strobe that captures wr_data, wr_dp and wr_blank.
REQ-008 The block SHALL have port wr_data, input, 12 bits: three hex nibbles; [3:0] is digit 0, [11:8] is digit 2.
REQ-009 The block SHALL have port wr_dp, input, 3 bits: per-digit decimal point request.
REQ-010 The block SHALL have port wr_blank, input, 3 bits: per-digit force-off request.
REQ-011 The block SHALL have port seg, output, 8 bits: [6:0] are segments a..g, [7] is dp.
REQ-012 The block SHALL have port seg_en, output, 3 bits: one digit enable per display position.
REQ-013 The block SHALL have port frame_tick, output, 1 bit: a one-cycle pulse when digit 2's slot ends.

Function
REQ-014 The block SHALL hold a slot counter cnt that counts 0..SCAN_DIV-1 and a digit index idx that counts 0,1,2 and wraps to 0; idx SHALL advance when cnt wraps.
REQ-015 The block SHALL implement a two-state FSM: GAP while cnt < GAP_CYC, and SHOW while GAP_CYC <= cnt <= SCAN_DIV-1; SHOW SHALL return to GAP on the cnt wrap.
REQ-016 In GAP, the block SHALL drive all segments and all digit enables inactive (ghosting suppression).
REQ-017 In SHOW, the block SHALL assert only seg_en[idx] and drive seg with the decode of display nibble idx, with seg[7] equal to that digit's dp bit.
REQ-018 In SHOW with blank[idx]=1, the block SHALL keep seg_en[idx] asserted and drive all segments inactive, including dp.
REQ-019 The decoder SHALL map active-high g..a patterns as follows: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-020 Polarity SHALL be applied by inversion at the output registers only.
REQ-021 seg, seg_en and frame_tick SHALL be registered; each SHALL reflect cnt/idx state with exactly 1 cycle of latency.
REQ-022 wr_en SHALL load a pending register set; pending SHALL copy into the display register set only on the cycle cnt wraps with idx=2, so that a frame never shows mixed data.
REQ-023 Multiple wr_en strobes within one frame SHALL be last-write-wins; the block SHALL apply no backpressure.
REQ-024 If wr_en coincides with the frame-boundary copy, the new data SHALL go to pending only and SHALL display from the next frame.
REQ-025 frame_tick SHALL pulse for exactly 1 cycle per 3*SCAN_DIV cycles, registered on the idx 2->0 transition.

Reset
REQ-026 When reset is asserted, the block SHALL set cnt=0, idx=0, FSM=GAP, and pending and display data, dp and blank to 0.
REQ-027 During reset and on the first cycle after it, the block SHALL drive seg all inactive (FF when SEG_ACT_LOW=1), seg_en all inactive (111 when EN_ACT_LOW=1), and frame_tick=0.
REQ-028 A reset asserted mid-slot or mid-frame SHALL discard any pending write and restart scanning at digit 0, GAP.

Structure
REQ-029 Package seg7_pkg SHALL hold the 16-entry hex-to-segment constant table, the FSM state enum {GAP, SHOW} and the digit count constant (3).
REQ-030 The decode SHALL be a sub-module seg7_hex_decode: purely combinational, 4-bit nibble in, 7-bit active-high g..a out.
REQ-031 The counter, FSM, register sets and output polarity stage SHALL live in seg7_scan.

Verification
REQ-032 Reset then idle with SCAN_DIV=40, GAP_CYC=4: seg=FF and seg_en=111 for cycles 0..4; from cycle 5, seg_en=110 and seg=C0.
REQ-033 Write 12'h18F, wr_dp=3'b010, mid-frame: the next frame SHALL show digit 0 seg=8E, digit 1 seg=00 (8 plus dp), digit 2 seg=F9; the current frame SHALL be unchanged.
REQ-034 Write 12'h123 then 12'h456 in the same frame: only 456 SHALL ever appear on the display.
REQ-035 wr_blank=3'b100: digit 2's slot SHALL show seg_en=011 with seg=FF; digits 0 and 1 SHALL be unaffected.
REQ-036 Count cycles between frame_tick pulses: exactly 120 for SCAN_DIV=40, and never two enables asserted in any cycle.
REQ-037 Assert reset during digit 1 SHOW with pending data present: outputs SHALL go inactive next cycle, and after release the display SHALL show 000.
